serial_pattern_detector: RTL

Downstream consumer of the D flip-flop's registered output: samples the serial bit stream on `out_Q` and produces registered results. It detects a parameterised bit pattern, with overlapping matches allowed, and flags rising and falling transitions. It also keeps saturating counts of matches and edges for status readout. It sits directly after the DFF stage on the same clock and gives the rest of the design a clean, one-cycle-pulse view of the stream.

---
 rtl/serial_pattern_detector.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector sitting behind the DFF stage.
// Shifts in in_Q on every in_en strobe, detects PATTERN (overlapping),
// flags rising/falling transitions as one-cycle pulses and keeps
// saturating match/edge counts. out_primed reports a full history window.
module serial_pattern_detector #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_Q,
  input  logic             in_en,
  output logic             out_detect,
  output logic             out_rise,
  output logic             out_fall,
  output logic [CNT_W-1:0] out_match_count,
  output logic [CNT_W-1:0] out_edge_count,
  output logic             out_primed
);

  localparam int unsigned    FW       = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN);

  typedef enum logic {
    S_FILL,
    S_ARMED
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] hist_q,  hist_d;
  logic [FW-1:0]      fill_q,  fill_d;
  logic               prev_q,  prev_d;
  logic               seen_q,  seen_d;
  logic               det_q,   det_d;
  logic               rise_q,  rise_d;
  logic               fall_q,  fall_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   edge_q,  edge_d;

  // State register: synchronous reset clears history, pulses and counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      seen_q  <= 1'b0;
      det_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      match_q <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      det_q   <= det_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      match_q <= match_d;
      edge_q  <= edge_d;
    end
  end

  // Next-state: shift on strobe, derive pulses and saturating counts.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
    det_d   = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    match_d = match_q;
    edge_d  = edge_q;

    if (in_en) begin
      // Shift-and-OR keeps the oldest bit falling off the top naturally.
      hist_d = (hist_q << 1) | PAT_LEN'(in_Q);
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
      det_d  = (fill_d == FILL_MAX) && (hist_d == PATTERN);
      rise_d = seen_q & ~prev_q &  in_Q;
      fall_d = seen_q &  prev_q & ~in_Q;
      prev_d = in_Q;
      seen_d = 1'b1;
      if (det_d && (match_q != '1)) begin
        match_d = match_q + CNT_W'(1);
      end
      if ((rise_d || fall_d) && (edge_q != '1)) begin
        edge_d = edge_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      S_FILL:  if (fill_d == FILL_MAX) state_d = S_ARMED;
      S_ARMED: state_d = S_ARMED;
      default: state_d = S_FILL;
    endcase
  end

  assign out_detect      = det_q;
  assign out_rise        = rise_q;
  assign out_fall        = fall_q;
  assign out_match_count = match_q;
  assign out_edge_count  = edge_q;
  assign out_primed      = (state_q == S_ARMED);

endmodule
